// File: rtl/if_id_latch.sv
`default_nettype none
// ============================================================================
// Module   : if_id_latch
// Purpose  : Fetch-to-decode pipeline register. Captures instruction, PC and
//            PC+2 each cycle, holds on stall, inserts a NOP bubble on flush
//            or fetch exception, and stops PC advance once a HALT is latched.
// Ports    : clk, rst_n (async, active-low)
//            instrIn/pcCurrentIn/pcPlusTwoIn  - fetch outputs
//            exception, stall, flush          - pipeline control
//            instrOut/pcCurrentOut/pcPlusTwoOut/validOut - to decode
//            pcWriteEN (combinational), halted
//            stallCount/bubbleCount           - only with IFID_PERF_CNT_EN
// Options  : define IFID_PERF_CNT_EN to add saturating stall/bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_latch #(
   parameter logic [15:0] NOP_INSTR = 16'h0800,
   parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] instrIn,
   input  logic [15:0] pcCurrentIn,
   input  logic [15:0] pcPlusTwoIn,
   input  logic        exception,
   input  logic        stall,
   input  logic        flush,
   output logic [15:0] instrOut,
   output logic [15:0] pcCurrentOut,
   output logic [15:0] pcPlusTwoOut,
   output logic        validOut,
   output logic        pcWriteEN,
`ifdef IFID_PERF_CNT_EN
   output logic [15:0] stallCount,
   output logic [15:0] bubbleCount,
`endif
   output logic        halted
);

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [15:0] r_instr;
   logic [15:0] r_pc_cur;
   logic [15:0] r_pc_p2;
   logic        r_valid;
   logic        w_halt_in;
   logic        w_run;

   // An excepting fetch word is garbage, so it must never be taken as HALT.
   assign w_halt_in = (instrIn[15:11] == HALT_OPC) & ~exception;
   assign w_run     = (r_state == ST_RUN);

   // Combinational so fetch freezes the PC in the very cycle HALT appears.
   // Flush overrides everything so the redirect target gets written.
   assign pcWriteEN = flush | (w_run & ~stall & ~w_halt_in);

   // ---------------- state machine ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_RUN;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (flush)
         w_state_next = ST_RUN;       // a same-cycle HALT is squashed too
      else if (w_run && !stall && w_halt_in)
         w_state_next = ST_HALTED;
   end

   // ---------------- datapath register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr  <= NOP_INSTR;
         r_pc_cur <= 16'h0000;
         r_pc_p2  <= 16'h0000;
         r_valid  <= 1'b0;
      end else if (flush) begin
         // PC outputs deliberately held on flush
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (stall || !w_run) begin
         // hold everything
      end else if (exception) begin
         // bubble still carries the faulting PC for the exception handler
         r_instr  <= NOP_INSTR;
         r_valid  <= 1'b0;
         r_pc_cur <= pcCurrentIn;
         r_pc_p2  <= pcPlusTwoIn;
      end else begin
         r_instr  <= instrIn;
         r_valid  <= 1'b1;
         r_pc_cur <= pcCurrentIn;
         r_pc_p2  <= pcPlusTwoIn;
      end
   end

   assign instrOut     = r_instr;
   assign pcCurrentOut = r_pc_cur;
   assign pcPlusTwoOut = r_pc_p2;
   assign validOut     = r_valid;
   assign halted       = (r_state == ST_HALTED);

`ifdef IFID_PERF_CNT_EN
   // ---------------- performance counters ----------------
   logic [15:0] r_stall_cnt;
   logic [15:0] r_bubble_cnt;
   logic        w_stall_inc;
   logic        w_bubble_inc;

   assign w_stall_inc  = stall & ~flush & w_run;
   assign w_bubble_inc = flush | (w_run & ~stall & exception);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt  <= 16'h0000;
         r_bubble_cnt <= 16'h0000;
      end else begin
         if (w_stall_inc && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'h0001;
         if (w_bubble_inc && (r_bubble_cnt != 16'hFFFF))
            r_bubble_cnt <= r_bubble_cnt + 16'h0001;
      end
   end

   assign stallCount  = r_stall_cnt;
   assign bubbleCount = r_bubble_cnt;
`endif

endmodule
`default_nettype wire
